instruction_fetch_stage: RTL

- Sits directly downstream of the program counter.
- Issues the PC value as a read to the synchronous instruction memory (one-cycle read latency) and captures the returned word with its address.
- Buffers returned words in a small in-order queue and presents them to decode over a valid/ready handshake.
- Generates pc_hold back to the PC when the queue cannot accept further requests, and discards everything on a branch flush.

---
 rtl/instruction_fetch_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: issues the PC to a synchronous instruction memory,
// captures returned words with their address in a small in-order queue, and
// hands them to decode over valid/ready. Holds the PC when the queue cannot
// take another request and discards everything on a branch flush.
module instruction_fetch_stage #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_pc_addr,
  input  logic              i_branch_flush,
  output logic              o_pc_hold,
  output logic              o_imem_en,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_instr_valid,
  input  logic              i_dec_ready,
  output logic [DATA_W-1:0] o_instr_out,
  output logic [ADDR_W-1:0] o_instr_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);

  logic              r_req_valid;
  logic [ADDR_W-1:0] r_req_pc;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0] r_q_pc    [DEPTH];
  logic [DATA_W-1:0] r_q_instr [DEPTH];

  logic              w_pop;
  logic              w_write;
  logic              w_issue_ok;
  logic [CNT_W:0]    w_occ;
  logic [CNT_W-1:0]  w_count_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake, occupancy and issue decisions; everything forced quiet in reset.
  always_comb begin
    o_instr_valid = (r_count != '0) & ~i_branch_flush & ~i_reset;
    w_pop         = o_instr_valid & i_dec_ready;
    w_write       = r_req_valid & ~i_branch_flush;
    // Entries already committed (queued plus in flight) after this cycle's pop.
    w_occ         = {1'b0, r_count} + {{CNT_W{1'b0}}, r_req_valid}
                  - {{CNT_W{1'b0}}, w_pop};
    w_issue_ok    = (w_occ < DEPTH_C);
    o_imem_en     = w_issue_ok & ~i_branch_flush & ~i_reset;
    o_pc_hold     = ~w_issue_ok & ~i_branch_flush & ~i_reset;
    o_imem_addr   = i_pc_addr;
    o_instr_out   = i_reset ? '0 : r_q_instr[r_rd_ptr];
    o_instr_pc    = i_reset ? '0 : r_q_pc[r_rd_ptr];
  end

  // Next occupancy: simultaneous write and pop cancel out.
  always_comb begin
    w_count_next = r_count;
    unique case ({w_write, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Request tracking and queue state; flush overrides any write or pop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (i_branch_flush) begin
      r_req_valid <= 1'b0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
    end else begin
      r_req_valid <= o_imem_en;
      if (o_imem_en) begin
        r_req_pc <= i_pc_addr;
      end
      if (w_write) begin
        r_q_pc[r_wr_ptr]    <= r_req_pc;
        r_q_instr[r_wr_ptr] <= i_imem_rdata;
        r_wr_ptr            <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= w_count_next;
    end
  end

endmodule
